// File: rtl/execute_pipe.sv
// Execute stage: ALU, branch resolution and result register with a valid/ready handshake.
// Define EXECUTE_PIPE_MUL_EN to build the multi-cycle shift-add multiplier for op 8.
module execute_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] pc_inc,
   input  logic [WIDTH-1:0] pc_off,
   input  logic [3:0]       alu_op,
   input  logic             alu_src,
   input  logic             branch,
   input  logic             jump,
   input  logic [1:0]       br_type,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] pc_next,
   output logic             pc_src
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] pc_sum;
   logic [SHW-1:0]   shamt;
   logic             cond;
   logic             take;
   logic             accept;
   logic             busy;

   always_comb begin
      op_b  = alu_src ? imm : opb;
      shamt = op_b[SHW-1:0];
      case (alu_op)
         4'd0:    alu_res = opa + op_b;
         4'd1:    alu_res = opa - op_b;
         4'd2:    alu_res = opa & op_b;
         4'd3:    alu_res = opa | op_b;
         4'd4:    alu_res = opa ^ op_b;
         4'd5:    alu_res = opa << shamt;
         4'd6:    alu_res = opa >> shamt;
         4'd7:    alu_res = $unsigned($signed(opa) >>> shamt);
         4'd8:    alu_res = '0;
         default: alu_res = op_b;
      endcase
   end

   always_comb begin
      case (br_type)
         2'b00:   cond = (opa == '0);
         2'b01:   cond = (opa != '0);
         2'b10:   cond = opa[WIDTH-1];
         default: cond = ~opa[WIDTH-1];
      endcase
   end

   assign take     = jump | (branch & cond);
   assign pc_sum   = pc_inc + pc_off;
   assign in_ready = rst_n & ~busy & ~flush & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

`ifdef EXECUTE_PIPE_MUL_EN
   // state | meaning
   // IDLE  | accepting operations, single-cycle ops complete at acceptance
   // MUL   | shift-add multiply, one partial product per cycle, cnt counts down
   typedef enum logic {IDLE, MUL} state_t;

   localparam logic [SHW-1:0] CNT_TOP = SHW'(WIDTH - 1);

   state_t           state;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] mc;
   logic [WIDTH-1:0] mp;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] pc_next_h;
   logic             pc_src_h;

   assign busy     = (state != IDLE);
   assign acc_step = mp[0] ? acc + mc : acc;
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         pc_next   <= '0;
         pc_src    <= 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
         state     <= IDLE;
         cnt       <= '0;
         mc        <= '0;
         mp        <= '0;
         acc       <= '0;
         pc_next_h <= '0;
         pc_src_h  <= 1'b0;
`endif
      end else if (flush) begin
         out_valid <= 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
         state     <= IDLE;
         cnt       <= '0;
`endif
      end else begin
         if (out_ready)
            out_valid <= 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
         if (state == MUL) begin
            acc <= acc_step;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt - SHW'(1);
            if (cnt == '0) begin
               state     <= IDLE;
               result    <= acc_step;
               pc_next   <= pc_next_h;
               pc_src    <= pc_src_h;
               out_valid <= 1'b1;
            end
         end else if (accept && alu_op == 4'd8) begin
            // branch outcome is captured now and published with the product
            state     <= MUL;
            cnt       <= CNT_TOP;
            mc        <= opa;
            mp        <= op_b;
            acc       <= '0;
            pc_next_h <= pc_sum;
            pc_src_h  <= take;
         end else
`endif
         if (accept) begin
            result    <= alu_res;
            pc_next   <= pc_sum;
            pc_src    <= take;
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe (WIDTH=16): ALU ops, branches, backpressure, flush, reset,
// and the multi-cycle multiply when EXECUTE_PIPE_MUL_EN is defined.
module tb_execute_pipe;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready;
   logic [W-1:0] opa, opb, imm, pc_inc, pc_off;
   logic [3:0]   alu_op;
   logic         alu_src, branch, jump;
   logic [1:0]   br_type;
   logic         out_valid, out_ready;
   logic [W-1:0] result, pc_next;
   logic         pc_src;

   int errors = 0;
   int checks = 0;

   execute_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opa(opa), .opb(opb), .imm(imm), .pc_inc(pc_inc), .pc_off(pc_off),
      .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .jump(jump), .br_type(br_type),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .pc_next(pc_next),
      .pc_src(pc_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] im, input logic src);
      alu_op = op; opa = a; opb = b; imm = im; alu_src = src;
      branch = 1'b0; jump = 1'b0; br_type = 2'b00; pc_inc = '0; pc_off = '0;
      in_valid = 1'b1;
   endtask

   task automatic do_alu(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] im, input logic src,
                         input logic [W-1:0] exp);
      issue(op, a, b, im, src);
      #1;
      check({tag, "_ready"}, in_ready, 1'b1);
      tick();
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_result"}, result, exp);
   endtask

   task automatic do_br(input string tag, input logic br, input logic jmp, input logic [1:0] bt,
                        input logic [W-1:0] a, input logic [W-1:0] pinc, input logic [W-1:0] poff,
                        input logic exp_src, input logic [W-1:0] exp_next);
      issue(4'd0, a, 16'h0000, 16'h0000, 1'b0);
      branch = br; jump = jmp; br_type = bt; pc_inc = pinc; pc_off = poff;
      tick();
      check({tag, "_pc_src"}, pc_src, exp_src);
      check({tag, "_pc_next"}, pc_next, exp_next);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      issue(4'd0, '0, '0, '0, 1'b0);
      in_valid = 1'b0;

      tick(); tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_result", result, 16'h0000);
      check("rst_pc_next", pc_next, 16'h0000);
      check("rst_pc_src", pc_src, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);

      rst_n = 1'b1;
      #1;
      check("idle_in_ready", in_ready, 1'b1);

      // 3 - 5 wraps; result visible at the accepting edge
      do_alu("sub", 4'd1, 16'h0003, 16'h0005, 16'h0000, 1'b0, 16'hFFFE);
      in_valid = 1'b0;
      tick();
      check("sub_drain", out_valid, 1'b0);

      do_alu("add",  4'd0,  16'hFFFF, 16'h0002, 16'h0000, 1'b0, 16'h0001);
      do_alu("and",  4'd2,  16'hF0F0, 16'h0000, 16'h0FF0, 1'b1, 16'h00F0);
      do_alu("or",   4'd3,  16'hF000, 16'h000F, 16'h0000, 1'b0, 16'hF00F);
      do_alu("xor",  4'd4,  16'hAAAA, 16'hFFFF, 16'h0000, 1'b0, 16'h5555);
      do_alu("sll",  4'd5,  16'h0001, 16'h0013, 16'h0000, 1'b0, 16'h0008);
      do_alu("srl",  4'd6,  16'h8000, 16'h00F4, 16'h0000, 1'b0, 16'h0800);
      do_alu("sra",  4'd7,  16'h8000, 16'h0004, 16'h0000, 1'b0, 16'hF800);
      do_alu("pass9", 4'd9, 16'h5555, 16'h0000, 16'h1234, 1'b1, 16'h1234);
      do_alu("pass15", 4'd15, 16'h5555, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF);
`ifndef EXECUTE_PIPE_MUL_EN
      do_alu("mul_off", 4'd8, 16'h0123, 16'h0010, 16'h0000, 1'b0, 16'h0000);
`endif

      do_br("blt",  1'b1, 1'b0, 2'b10, 16'h8000, 16'h0010, 16'hFFF0, 1'b1, 16'h0000);
      do_br("beq",  1'b1, 1'b0, 2'b00, 16'h0005, 16'h0100, 16'h0020, 1'b0, 16'h0120);
      do_br("bne",  1'b1, 1'b0, 2'b01, 16'h0005, 16'h0200, 16'h0004, 1'b1, 16'h0204);
      do_br("bge",  1'b1, 1'b0, 2'b11, 16'h8000, 16'h0010, 16'h0010, 1'b0, 16'h0020);
      do_br("jal",  1'b0, 1'b1, 2'b00, 16'h0005, 16'h0040, 16'h0008, 1'b1, 16'h0048);
      do_br("nobr", 1'b0, 1'b0, 2'b01, 16'h0005, 16'h0040, 16'h0008, 1'b0, 16'h0048);

      // backpressure: held result survives three stalled cycles
      issue(4'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0);
      tick();
      check("bp_first", result, 16'h0003);
      out_ready = 1'b0;
      issue(4'd0, 16'h000A, 16'h000A, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", in_ready, 1'b0);
         tick();
         check("bp_valid", out_valid, 1'b1);
         check("bp_result", result, 16'h0003);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1'b1);
      tick();
      check("bp_b2b_valid", out_valid, 1'b1);
      check("bp_b2b_result", result, 16'h0014);
      in_valid = 1'b0;
      tick();
      check("bp_drain", out_valid, 1'b0);

      // flush kills a held result and drops the op presented with it
      issue(4'd3, 16'h0001, 16'h0002, 16'h0000, 1'b0);
      tick();
      check("fl_pre_valid", out_valid, 1'b1);
      out_ready = 1'b0;
      flush = 1'b1;
      issue(4'd0, 16'h0005, 16'h0005, 16'h0000, 1'b0);
      #1;
      check("fl_in_ready", in_ready, 1'b0);
      tick();
      check("fl_valid", out_valid, 1'b0);
      check("fl_result_kept", result, 16'h0003);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check("fl_after_ready", in_ready, 1'b1);

`ifdef EXECUTE_PIPE_MUL_EN
      // 0x0123 * 0x0010 completes WIDTH edges after acceptance
      issue(4'd8, 16'h0123, 16'h0010, 16'h0000, 1'b0);
      jump = 1'b1; pc_inc = 16'h0004; pc_off = 16'h0004;
      tick();
      in_valid = 1'b0;
      check("mul_n_valid", out_valid, 1'b0);
      for (int i = 1; i < W; i++) begin
         #1;
         check("mul_in_ready", in_ready, 1'b0);
         tick();
         check("mul_wait_valid", out_valid, 1'b0);
      end
      #1;
      check("mul_last_in_ready", in_ready, 1'b0);
      tick();
      check("mul_valid", out_valid, 1'b1);
      check("mul_result", result, 16'h1230);
      check("mul_pc_next", pc_next, 16'h0008);
      check("mul_pc_src", pc_src, 1'b1);
      tick();
      check("mul_drain", out_valid, 1'b0);

      // flush at the fifth MUL edge aborts the multiply
      issue(4'd8, 16'h0007, 16'h0003, 16'h0000, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("mfl_valid", out_valid, 1'b0);
      #1;
      check("mfl_in_ready", in_ready, 1'b1);
      for (int i = 0; i < W + 2; i++) begin
         tick();
         check("mfl_no_complete", out_valid, 1'b0);
      end

      // start a multiply so reset lands mid-MUL
      issue(4'd8, 16'h0003, 16'h0003, 16'h0000, 1'b0);
      tick();
      in_valid = 1'b0;
      tick(); tick();
`else
      issue(4'd0, 16'h0003, 16'h0003, 16'h0000, 1'b0);
      jump = 1'b1; pc_inc = 16'h0004; pc_off = 16'h0004;
      tick();
      in_valid = 1'b0;
      check("pre_rst_result", result, 16'h0006);
`endif
      rst_n = 1'b0;
      tick();
      check("mrst_valid", out_valid, 1'b0);
      check("mrst_result", result, 16'h0000);
      check("mrst_pc_next", pc_next, 16'h0000);
      check("mrst_pc_src", pc_src, 1'b0);
      check("mrst_in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      #1;
      check("mrst_idle_ready", in_ready, 1'b1);
      for (int i = 0; i < W + 2; i++) begin
         tick();
         check("mrst_no_complete", out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
